// File: rtl/if_id_pipeline_reg.sv
// IF/ID pipeline register: captures PC+4 and instruction, exposes decoded fields.
// Optional performance counters are built when IFID_PERF_CNT_EN is defined.
module if_id_pipeline_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] NOP_INSTR = 32'h0000_0000,
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] if_pc4,
    input  logic [WIDTH-1:0] if_instr,
    input  logic             if_valid,
    output logic [WIDTH-1:0] id_pc4,
    output logic [WIDTH-1:0] id_instr,
    output logic             id_valid,
    output logic [5:0]       id_opcode,
    output logic [4:0]       id_rs,
    output logic [4:0]       id_rt,
    output logic [4:0]       id_rd,
    output logic [4:0]       id_shamt,
    output logic [5:0]       id_funct,
    output logic [15:0]      id_imm16,
    output logic [25:0]      id_jaddr,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic [WIDTH-1:0] pc4_q,   pc4_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic             valid_q, valid_d;

    // Flush outranks stall so a squashed instruction never lingers in ID.
    always_comb begin
        // NOTE: defaults first so every path assigns every _d; no latches inferred.
        pc4_d   = pc4_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (flush_i) begin
            pc4_d   = '0;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (!stall_i) begin
            pc4_d   = if_pc4;
            instr_d = if_instr;
            valid_d = if_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments for state; reset loads the bubble encoding.
        if (!rst_n) begin
            pc4_q   <= '0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else begin
            pc4_q   <= pc4_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign id_pc4    = pc4_q;
    assign id_instr  = instr_q;
    assign id_valid  = valid_q;

    // Field slices come straight off the register, adding no latency.
    assign id_opcode = instr_q[31:26];
    assign id_rs     = instr_q[25:21];
    assign id_rt     = instr_q[20:16];
    assign id_rd     = instr_q[15:11];
    assign id_shamt  = instr_q[10:6];
    assign id_funct  = instr_q[5:0];
    assign id_imm16  = instr_q[15:0];
    assign id_jaddr  = instr_q[25:0];

`ifdef IFID_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating counters: a stall cycle that is also flushed counts as a flush only.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_i && !flush_i && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (flush_i && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_if_id_pipeline_reg.sv
// Scoreboard bench for if_id_pipeline_reg: stimulus pushes expectations, a monitor
// pops and compares one cycle later. Counter expectations follow IFID_PERF_CNT_EN.
module tb_if_id_pipeline_reg;

    localparam int          WIDTH = 32;
    localparam logic [31:0] NOP   = 32'h0000_0000;
`ifdef IFID_PERF_CNT_EN
    localparam int          CNT_W = 2;
`else
    localparam int          CNT_W = 16;
`endif
    localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

    logic             clk;
    logic             rst_n;
    logic             stall_i;
    logic             flush_i;
    logic [WIDTH-1:0] if_pc4;
    logic [WIDTH-1:0] if_instr;
    logic             if_valid;
    logic [WIDTH-1:0] id_pc4;
    logic [WIDTH-1:0] id_instr;
    logic             id_valid;
    logic [5:0]       id_opcode;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic [4:0]       id_rd;
    logic [4:0]       id_shamt;
    logic [5:0]       id_funct;
    logic [15:0]      id_imm16;
    logic [25:0]      id_jaddr;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    if_id_pipeline_reg #(
        .WIDTH    (WIDTH),
        .NOP_INSTR(NOP),
        .CNT_W    (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .stall_i  (stall_i),
        .flush_i  (flush_i),
        .if_pc4   (if_pc4),
        .if_instr (if_instr),
        .if_valid (if_valid),
        .id_pc4   (id_pc4),
        .id_instr (id_instr),
        .id_valid (id_valid),
        .id_opcode(id_opcode),
        .id_rs    (id_rs),
        .id_rt    (id_rt),
        .id_rd    (id_rd),
        .id_shamt (id_shamt),
        .id_funct (id_funct),
        .id_imm16 (id_imm16),
        .id_jaddr (id_jaddr),
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] pc4;
        logic [WIDTH-1:0] instr;
        logic             valid;
        logic [CNT_W-1:0] scnt;
        logic [CNT_W-1:0] fcnt;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] m_pc4;
    logic [WIDTH-1:0] m_instr;
    logic             m_valid;
    logic [CNT_W-1:0] m_scnt;
    logic [CNT_W-1:0] m_fcnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc4   = '0;
        m_instr = NOP;
        m_valid = 1'b0;
        m_scnt  = '0;
        m_fcnt  = '0;
    endtask

    // Called at a negedge: drive inputs, record expectation, return at the next negedge.
    task automatic step(input string name, input logic st, input logic fl,
                        input logic [31:0] pc4, input logic [31:0] instr, input logic vld);
        exp_t e;
        stall_i  = st;
        flush_i  = fl;
        if_pc4   = pc4;
        if_instr = instr;
        if_valid = vld;
        if (fl) begin
            m_pc4   = '0;
            m_instr = NOP;
            m_valid = 1'b0;
        end else if (!st) begin
            m_pc4   = pc4;
            m_instr = instr;
            m_valid = vld;
        end
`ifdef IFID_PERF_CNT_EN
        if (st && !fl && m_scnt != CMAX) m_scnt = m_scnt + 1'b1;
        if (fl && m_fcnt != CMAX)        m_fcnt = m_fcnt + 1'b1;
`endif
        e.name  = name;
        e.pc4   = m_pc4;
        e.instr = m_instr;
        e.valid = m_valid;
        e.scnt  = m_scnt;
        e.fcnt  = m_fcnt;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            check({mon_e.name, ".pc4"},    64'(id_pc4),    64'(mon_e.pc4));
            check({mon_e.name, ".instr"},  64'(id_instr),  64'(mon_e.instr));
            check({mon_e.name, ".valid"},  64'(id_valid),  64'(mon_e.valid));
            check({mon_e.name, ".opcode"}, 64'(id_opcode), 64'(mon_e.instr[31:26]));
            check({mon_e.name, ".rs"},     64'(id_rs),     64'(mon_e.instr[25:21]));
            check({mon_e.name, ".rt"},     64'(id_rt),     64'(mon_e.instr[20:16]));
            check({mon_e.name, ".rd"},     64'(id_rd),     64'(mon_e.instr[15:11]));
            check({mon_e.name, ".shamt"},  64'(id_shamt),  64'(mon_e.instr[10:6]));
            check({mon_e.name, ".funct"},  64'(id_funct),  64'(mon_e.instr[5:0]));
            check({mon_e.name, ".imm16"},  64'(id_imm16),  64'(mon_e.instr[15:0]));
            check({mon_e.name, ".jaddr"},  64'(id_jaddr),  64'(mon_e.instr[25:0]));
            check({mon_e.name, ".scnt"},   64'(stall_cnt), 64'(mon_e.scnt));
            check({mon_e.name, ".fcnt"},   64'(flush_cnt), 64'(mon_e.fcnt));
        end
    end

    task automatic check_reset_state(input string name);
        check({name, ".pc4"},   64'(id_pc4),    64'h0);
        check({name, ".instr"}, 64'(id_instr),  64'(NOP));
        check({name, ".valid"}, 64'(id_valid),  64'h0);
        check({name, ".scnt"},  64'(stall_cnt), 64'h0);
        check({name, ".fcnt"},  64'(flush_cnt), 64'h0);
    endtask

    initial begin
        rst_n    = 1'b1;
        stall_i  = 1'b0;
        flush_i  = 1'b0;
        if_pc4   = '0;
        if_instr = '0;
        if_valid = 1'b0;
        model_reset();

        // Async reset before the first clock edge.
        #2 rst_n = 1'b0;
        #1 check_reset_state("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        step("load_addi", 1'b0, 1'b0, 32'h0000_0008, 32'h2008_FFFC, 1'b1);
        check("load_addi.opcode_const", 64'(id_opcode), 64'h08);
        check("load_addi.rt_const",     64'(id_rt),     64'd8);
        check("load_addi.imm_const",    64'(id_imm16),  64'hFFFC);
        check("load_addi.valid_const",  64'(id_valid),  64'h1);

        step("stall1", 1'b1, 1'b0, 32'h0000_000C, 32'h1111_1111, 1'b1);
        step("stall2", 1'b1, 1'b0, 32'h0000_0010, 32'h2222_2222, 1'b1);
        step("stall3", 1'b1, 1'b0, 32'h0000_0014, 32'h3333_3333, 1'b1);
        check("stall3.held_const", 64'(id_instr), 64'h2008_FFFC);

        step("release_lw", 1'b0, 1'b0, 32'h0000_0018, 32'h8C48_0004, 1'b1);
        check("release_lw.instr_const", 64'(id_instr), 64'h8C48_0004);

        step("rtype_add", 1'b0, 1'b0, 32'h0000_001C, 32'h0109_5020, 1'b1);
        check("rtype_add.rd_const",    64'(id_rd),    64'd10);
        check("rtype_add.funct_const", 64'(id_funct), 64'h20);

        step("invalid_cap", 1'b0, 1'b0, 32'h0000_0020, 32'hDEAD_BEEF, 1'b0);
        check("invalid_cap.instr_const", 64'(id_instr), 64'hDEAD_BEEF);
        check("invalid_cap.valid_const", 64'(id_valid), 64'h0);

        step("jump", 1'b0, 1'b0, 32'h0000_0024, 32'h0800_0040, 1'b1);
        check("jump.jaddr_const", 64'(id_jaddr), 64'h40);

        step("flush_stall", 1'b1, 1'b1, 32'h0000_0028, 32'hAAAA_5555, 1'b1);
        check("flush_stall.instr_const", 64'(id_instr), 64'(NOP));
        check("flush_stall.pc4_const",   64'(id_pc4),   64'h0);

        step("sll_shamt", 1'b0, 1'b0, 32'h0000_0030, 32'h0009_4080, 1'b1);
        check("sll_shamt.shamt_const", 64'(id_shamt), 64'd2);

        step("flush_only", 1'b0, 1'b1, 32'h0000_0034, 32'h1234_5678, 1'b1);

        for (int i = 0; i < 5; i++) begin
            step("long_stall", 1'b1, 1'b0, 32'h0000_0040 + 32'(i * 4), 32'hF0F0_0000 + 32'(i), 1'b1);
        end
`ifdef IFID_PERF_CNT_EN
        check("long_stall.scnt_sat", 64'(stall_cnt), 64'd3);
        check("long_stall.fcnt",     64'(flush_cnt), 64'd2);
`else
        check("long_stall.scnt_off", 64'(stall_cnt), 64'd0);
        check("long_stall.fcnt_off", 64'(flush_cnt), 64'd0);
`endif

        step("post_stall_load", 1'b0, 1'b0, 32'h0000_0060, 32'h2008_0001, 1'b1);

        // Reset asserted mid-cycle while a stall is pending.
        stall_i = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_reset_state("mid_reset");
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        step("after_reset", 1'b0, 1'b0, 32'h0000_0070, 32'h2009_0007, 1'b1);

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
        check("drain_timeout", 64'(sb_q.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
